// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction prefetch unit.
package fetch_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2
   } fetch_state_e;

   localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
   localparam logic [2:0] ARPROT_INSTR  = 3'b100;
   localparam int unsigned FETCH_XLEN   = 32;

   // Field order matches the packed queue entry used in the top: {data, pc, fault}.
   typedef struct packed {
      logic [FETCH_XLEN-1:0] data;
      logic [FETCH_XLEN-1:0] pc;
      logic                  fault;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO with flush; holds instruction entries or outstanding PC tags.
module fetch_queue #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush,
   input  logic                         push,
   input  logic [WIDTH-1:0]             push_data,
   input  logic                         pop,
   output logic [WIDTH-1:0]             pop_data,
   output logic                         empty,
   output logic                         full,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH-1)) ? '0 : p + 1'b1;
   endfunction

   assign empty    = (count == '0);
   assign full     = (count == CW'(DEPTH));
   assign do_pop   = pop && !empty;
   assign do_push  = push && (!full || do_pop);
   assign pop_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push && !flush) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= ptr_inc(wr_ptr);
         end
         if (do_pop) begin
            rd_ptr <= ptr_inc(rd_ptr);
         end
         unique case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Pipelined AXI4-Lite instruction prefetcher with redirect/flush.
// Optional performance counters are built when FETCH_PERF_EN is defined.
//
// state   | meaning
// S_IDLE  | one cycle after reset, no AXI activity
// S_RUN   | issuing reads, accepting responses
// S_DRAIN | after redirect, discarding stale responses; no new reads
module fetch_prefetch_unit
   import fetch_pkg::*;
#(
   parameter int unsigned     XLEN            = 32,
   parameter int unsigned     IMADDRLEN       = 8,
   parameter int unsigned     DEPTH           = 4,
   parameter int unsigned     MAX_OUTSTANDING = 2,
   parameter logic [XLEN-1:0] RESET_PC        = '0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_redirect_valid,
   input  logic [XLEN-1:0]      i_redirect_pc,
   output logic                 o_instr_valid,
   input  logic                 i_instr_ready,
   output logic [XLEN-1:0]      o_instr_data,
   output logic [XLEN-1:0]      o_instr_pc,
   output logic                 o_instr_fault,
   output logic [IMADDRLEN-1:0] o_araddr,
   output logic [2:0]           o_arprot,
   output logic                 o_arvalid,
   input  logic                 i_arready,
   input  logic [XLEN-1:0]      i_rdata,
   input  logic [1:0]           i_rresp,
   input  logic                 i_rvalid,
   output logic                 o_rready
`ifdef FETCH_PERF_EN
   ,
   output logic [XLEN-1:0]      o_perf_delivered,
   output logic [XLEN-1:0]      o_perf_dropped
`endif
);

   localparam int unsigned QCW = $clog2(DEPTH+1);
   localparam int unsigned TCW = $clog2(MAX_OUTSTANDING+1);
   localparam int unsigned OCW = $clog2(MAX_OUTSTANDING+1);
   localparam int unsigned EW  = 2*XLEN + 1;

   fetch_state_e         state, state_n;
   logic [XLEN-1:0]      fetch_pc, pc_n;
   logic [OCW-1:0]       outstanding, drop;
   logic                 arvalid_q, ar_stale;
   logic [IMADDRLEN-1:0] araddr_q;

   logic                 ar_hs, r_hs, r_keep, r_drop, pop;
   logic                 issue_n;
   int                   out_n, occ_n, drop_n;

   logic [EW-1:0]        q_head;
   logic                 q_empty, q_full;
   logic [QCW-1:0]       q_count;
   logic [XLEN-1:0]      tag_pc;
   logic                 tag_empty, tag_full;
   logic [TCW-1:0]       tag_count;

   assign ar_hs   = arvalid_q && i_arready;
   assign r_hs    = i_rvalid && o_rready;
   assign r_keep  = r_hs && (drop == '0);
   assign r_drop  = r_hs && (drop != '0);
   assign pop     = o_instr_valid && i_instr_ready;

   assign o_arvalid     = arvalid_q;
   assign o_araddr      = araddr_q;
   assign o_arprot      = ARPROT_INSTR;
   assign o_rready      = (state != S_IDLE);
   assign o_instr_valid = !q_empty;
   assign o_instr_data  = q_head[EW-1 -: XLEN];
   assign o_instr_pc    = q_head[XLEN:1];
   assign o_instr_fault = !q_empty && q_head[0];

   always_comb begin
      out_n = int'(outstanding) + int'(ar_hs) - int'(r_hs);
      occ_n = i_redirect_valid ? 0 : int'(q_count) + int'(r_keep) - int'(pop);
      // A still-pending AR will complete later; its beat must be dropped too.
      drop_n = i_redirect_valid ? out_n + int'(arvalid_q && !i_arready)
                                : int'(drop) - int'(r_drop);

      if (i_redirect_valid) begin
         pc_n = {i_redirect_pc[XLEN-1:2], 2'b00};
      end else if (ar_hs && !ar_stale) begin
         pc_n = fetch_pc + XLEN'(4);
      end else begin
         pc_n = fetch_pc;
      end

      state_n = state;
      if (i_redirect_valid) begin
         state_n = (drop_n > 0) ? S_DRAIN : S_RUN;
      end else begin
         unique case (state)
            S_IDLE:  state_n = S_RUN;
            S_RUN:   state_n = S_RUN;
            S_DRAIN: state_n = (drop_n == 0) ? S_RUN : S_DRAIN;
            default: state_n = S_IDLE;
         endcase
      end

      issue_n = (state_n == S_RUN) && (out_n < int'(MAX_OUTSTANDING))
                && (occ_n + out_n < int'(DEPTH));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         fetch_pc    <= RESET_PC;
         outstanding <= '0;
         drop        <= '0;
         arvalid_q   <= 1'b0;
         araddr_q    <= '0;
         ar_stale    <= 1'b0;
      end else begin
         state       <= state_n;
         fetch_pc    <= pc_n;
         outstanding <= OCW'(out_n);
         drop        <= OCW'(drop_n);
         if (!arvalid_q || ar_hs) begin
            arvalid_q <= issue_n;
            araddr_q  <= {pc_n[IMADDRLEN-1:2], 2'b00};
            ar_stale  <= 1'b0;
         end else if (i_redirect_valid) begin
            ar_stale  <= 1'b1;
         end
      end
   end

   fetch_queue #(.WIDTH(EW), .DEPTH(DEPTH)) u_instr_q (
      .clk       (clk),
      .rst       (rst),
      .flush     (i_redirect_valid),
      .push      (r_keep),
      .push_data ({i_rdata, tag_pc, (i_rresp != AXI_RESP_OKAY)}),
      .pop       (pop),
      .pop_data  (q_head),
      .empty     (q_empty),
      .full      (q_full),
      .count     (q_count)
   );

   // Stale ARs are never tagged: their beats are dropped, not delivered.
   fetch_queue #(.WIDTH(XLEN), .DEPTH(MAX_OUTSTANDING)) u_tag_q (
      .clk       (clk),
      .rst       (rst),
      .flush     (i_redirect_valid),
      .push      (ar_hs && !ar_stale),
      .push_data (fetch_pc),
      .pop       (r_keep),
      .pop_data  (tag_pc),
      .empty     (tag_empty),
      .full      (tag_full),
      .count     (tag_count)
   );

   logic unused_ok;
   assign unused_ok = ^{q_full, tag_empty, tag_full, tag_count, i_redirect_pc[1:0]};

`ifdef FETCH_PERF_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         o_perf_delivered <= '0;
         o_perf_dropped   <= '0;
      end else begin
         if (pop && !(&o_perf_delivered)) begin
            o_perf_delivered <= o_perf_delivered + 1'b1;
         end
         if (r_drop && !(&o_perf_dropped)) begin
            o_perf_dropped <= o_perf_dropped + 1'b1;
         end
      end
   end
`endif

endmodule
